data_mem_responder: RTL and testbench

- Multi-cycle responder (slave) for CPU data-memory load/store requests over a valid/ready request channel and a valid/ready response channel.
- Replaces the single-cycle data memory once the core moves to a stalled/pipelined LSU.
- Performs little-endian byte/half/word access with RV32I load sign/zero extension, a programmable access latency and misaligned-access detection.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings, FSM state type and lane/legality helpers shared by
// data_mem_responder and dmem_lane_align.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Effective byte lane: halfwords and words are forced onto their natural boundary.
  function automatic logic [1:0] lane_sel(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return {addr_lo[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return addr_lo;
    endcase
  endfunction

  // Stores only exist in B/H/W form; unsigned widths are load-only.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for stores (byte enables, replicated
// write word) and loads (lane extraction with RV32I sign/zero extension).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wword,
  input  logic [31:0] raw,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? raw[31:16] : raw[15:0];
    be       = 4'b0000;
    wword    = wdata;
    rdata    = 32'd0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
        rdata = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        be    = 4'b1111;
        rdata = raw;
      end
      F3_BU:   rdata = {24'd0, byte_sel};
      F3_HU:   rdata = {16'd0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle valid/ready data-memory slave with RV32I widths.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses instead of force-aligning them.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 17,
  parameter int    LATENCY    = 2,
  parameter string MEM_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         WORDS    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic capture, exec;

  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic [2:0]            funct3_reg;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic [2:0]            sel_funct3;
  logic [1:0]            sel_lane;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic                  access_err;
  logic [3:0]            be;
  logic [31:0]           wword;
  logic [31:0]           rdata_ext;
  logic [31:0]           mem_q;
  logic                  unused_addr_bits;

  logic [31:0] mem [WORDS];

  // With LATENCY==1 the access executes on the accepting edge, so IDLE steers the live request.
  assign sel_we     = (state_reg == IDLE) ? req_we : we_reg;
  assign sel_addr   = (state_reg == IDLE) ? req_addr[ADDR_WIDTH-1:0] : addr_reg;
  assign sel_wdata  = (state_reg == IDLE) ? req_wdata : wdata_reg;
  assign sel_funct3 = (state_reg == IDLE) ? req_funct3 : funct3_reg;
  assign sel_lane   = lane_sel(sel_funct3, sel_addr[1:0]);
  assign word_idx   = sel_addr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH];

`ifdef DMEM_MISALIGN_ERR_EN
  assign access_err = funct3_illegal(sel_we, sel_funct3) | misaligned(sel_funct3, sel_addr[1:0]);
`else
  assign access_err = funct3_illegal(sel_we, sel_funct3);
`endif

  dmem_lane_align u_align (
    .funct3 (sel_funct3),
    .lane   (sel_lane),
    .wdata  (sel_wdata),
    .be     (be),
    .wword  (wword),
    .raw    (mem_q),
    .rdata  (rdata_ext)
  );

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_err   = resp_valid & access_err;
  assign resp_rdata = (resp_valid && !we_reg && !access_err) ? rdata_ext : 32'd0;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    exec       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            exec       = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = CNT_INIT;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          exec       = 1'b1;
          cnt_next   = 4'd0;
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= 32'd0;
      funct3_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        we_reg     <= req_we;
        addr_reg   <= req_addr[ADDR_WIDTH-1:0];
        wdata_reg  <= req_wdata;
        funct3_reg <= req_funct3;
      end
    end
  end

  // Array kept out of the reset domain so contents survive reset; rst still vetoes a write.
  always_ff @(posedge clk) begin
    if (exec && !rst && !access_err) begin
      if (sel_we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
        end
      end else begin
        mem_q <= mem[word_idx];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a
// byte-addressed reference memory model.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [7:0] bmem [int];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp;
  } dir_t;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(LAT), .MEM_FILE("")) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // ---------------- reference model ----------------
  function automatic int sz(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int base(input logic [31:0] addr, input logic [2:0] f3);
    int a = int'(addr & 32'h1FFFF);
    return a - (a % sz(f3));
  endfunction

  function automatic logic exp_err(input logic we, input logic [31:0] addr, input logic [2:0] f3);
    logic bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
`ifdef DMEM_MISALIGN_ERR_EN
    if ((int'(addr & 32'h3) % sz(f3)) != 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [2:0] f3);
    int b = base(addr, f3);
    if (exp_err(1'b1, addr, f3)) return;
    for (int k = 0; k < sz(f3); k++) bmem[b + k] = 8'(wdata >> (8 * k));
  endfunction

  function automatic logic known(input logic [31:0] addr, input logic [2:0] f3);
    int b = base(addr, f3);
    for (int k = 0; k < sz(f3); k++) if (!bmem.exists(b + k)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [2:0] f3);
    int     n = sz(f3);
    int     b = base(addr, f3);
    longint v = 0;
    if (exp_err(1'b0, addr, f3)) return 32'd0;
    for (int k = 0; k < n; k++) v += longint'(bmem[b + k]) << (8 * k);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  // Called at #1 after a rising edge; returns with the DUT idle again unless resp_ready is low.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, output logic [31:0] rd, output logic er,
                     output int lat, output logic rdy_bad);
    int guard = 0;
    rdy_bad = 1'b0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      if (req_ready !== 1'b0) rdy_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) lat = -1;
    if (req_ready !== 1'b0) rdy_bad = 1'b1;
    rd = resp_rdata;
    er = resp_err;
    if (resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    cmp_cnt += 4;
    if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    if (resp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    if (resp_rdata !== 32'd0) begin err_cnt++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
    if (resp_err !== 1'b0) begin err_cnt++; $display("FAIL reset_err got=%b want=0", resp_err); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    dir_t tbl [8];
    logic [31:0] rd; logic er, rb; int lat;
    tbl[0] = '{1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0};
    tbl[1] = '{1'b0, 32'h100, 32'h0,        3'b010, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 32'h100, 32'h0,        3'b000, 32'hFFFFFFEF};
    tbl[3] = '{1'b0, 32'h101, 32'h0,        3'b100, 32'h000000BE};
    tbl[4] = '{1'b0, 32'h102, 32'h0,        3'b001, 32'hFFFFDEAD};
    tbl[5] = '{1'b0, 32'h102, 32'h0,        3'b101, 32'h0000DEAD};
    tbl[6] = '{1'b1, 32'h103, 32'hAAAAAA55, 3'b000, 32'h0};
    tbl[7] = '{1'b0, 32'h100, 32'h0,        3'b010, 32'h55ADBEEF};
    foreach (tbl[i]) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, rd, er, lat, rb);
      if (tbl[i].we) model_store(tbl[i].addr, tbl[i].wdata, tbl[i].f3);
      $display("directed[%0d] we=%b addr=%h f3=%0d rdata=%h err=%b lat=%0d", i, tbl[i].we,
               tbl[i].addr, tbl[i].f3, rd, er, lat);
      cmp_cnt += 4;
      if (rd !== tbl[i].exp) begin err_cnt++; $display("FAIL directed_rdata[%0d] got=%h want=%h", i, rd, tbl[i].exp); end
      if (er !== 1'b0) begin err_cnt++; $display("FAIL directed_err[%0d] got=%b want=0", i, er); end
      if (lat != LAT) begin err_cnt++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
      if (rb !== 1'b0) begin err_cnt++; $display("FAIL directed_req_ready_busy[%0d] got=%b want=0", i, rb); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, want_lw, want_after; logic er, rb, want_err; int lat;
`ifdef DMEM_MISALIGN_ERR_EN
    want_err = 1'b1; want_lw = 32'h0; want_after = 32'h55ADBEEF;
`else
    want_err = 1'b0; want_lw = 32'h55ADBEEF; want_after = 32'h55AD1234;
`endif
    txn(1'b0, 32'h102, 32'h0, 3'b010, rd, er, lat, rb);
    $display("misalign LW 0x102 rdata=%h err=%b", rd, er);
    cmp_cnt += 2;
    if (rd !== want_lw) begin err_cnt++; $display("FAIL misalign_lw_rdata got=%h want=%h", rd, want_lw); end
    if (er !== want_err) begin err_cnt++; $display("FAIL misalign_lw_err got=%b want=%b", er, want_err); end
    txn(1'b1, 32'h101, 32'hFFFF1234, 3'b001, rd, er, lat, rb);
    model_store(32'h101, 32'hFFFF1234, 3'b001);
    $display("misalign SH 0x101 err=%b", er);
    cmp_cnt += 1;
    if (er !== want_err) begin err_cnt++; $display("FAIL misalign_sh_err got=%b want=%b", er, want_err); end
    txn(1'b0, 32'h100, 32'h0, 3'b010, rd, er, lat, rb);
    $display("misalign LW 0x100 after SH rdata=%h", rd);
    cmp_cnt += 1;
    if (rd !== want_after) begin err_cnt++; $display("FAIL misalign_sh_effect got=%h want=%h", rd, want_after); end
  endtask

  task automatic test_illegal();
    logic [31:0] rd, want; logic er, rb; int lat;
    txn(1'b0, 32'h100, 32'h0, 3'b011, rd, er, lat, rb);
    $display("illegal load f3=3 rdata=%h err=%b", rd, er);
    cmp_cnt += 2;
    if (er !== 1'b1) begin err_cnt++; $display("FAIL illegal_load_err got=%b want=1", er); end
    if (rd !== 32'd0) begin err_cnt++; $display("FAIL illegal_load_rdata got=%h want=0", rd); end
    txn(1'b1, 32'h100, 32'hFFFFFFFF, 3'b101, rd, er, lat, rb);
    $display("illegal store f3=5 err=%b", er);
    cmp_cnt += 1;
    if (er !== 1'b1) begin err_cnt++; $display("FAIL illegal_store_err got=%b want=1", er); end
    want = exp_load(32'h100, 3'b010);
    txn(1'b0, 32'h100, 32'h0, 3'b010, rd, er, lat, rb);
    $display("illegal store no-write check rdata=%h", rd);
    cmp_cnt += 1;
    if (rd !== want) begin err_cnt++; $display("FAIL illegal_store_nowrite got=%h want=%h", rd, want); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, want; logic er, rb; int lat; int bad;
    want = exp_load(32'h100, 3'b010);
    resp_ready = 1'b0;
    txn(1'b0, 32'h100, 32'h0, 3'b010, rd, er, lat, rb);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== want || req_ready !== 1'b0) bad++;
    end
    $display("backpressure held 5 cycles rdata=%h stall_errors=%0d", resp_rdata, bad);
    cmp_cnt += 2;
    if (rd !== want) begin err_cnt++; $display("FAIL bp_rdata got=%h want=%h", rd, want); end
    if (bad != 0) begin err_cnt++; $display("FAIL bp_stable got=%0d bad cycles want=0", bad); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    cmp_cnt += 2;
    if (resp_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_release_valid got=%b want=0", resp_valid); end
    if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int nresp = 0, bad_data = 0, guard = 0;
    logic rdy;
    logic [31:0] want = exp_load(32'h100, 3'b010);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_funct3 = 3'b010;
    for (int c = 0; c < 12; c++) begin
      rdy = req_ready;
      if (resp_valid) begin
        nresp++;
        if (resp_rdata !== want) bad_data++;
      end
      @(posedge clk); #1;
      if (rdy) acc.push_back(c);
    end
    req_valid = 1'b0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    $display("back_to_back accepts=%0d responses=%0d", acc.size(), nresp);
    cmp_cnt += 2;
    if (acc.size() != 4) begin err_cnt++; $display("FAIL b2b_accept_count got=%0d want=4", acc.size()); end
    if (bad_data != 0) begin err_cnt++; $display("FAIL b2b_rdata got=%0d bad want=0", bad_data); end
    for (int i = 1; i < acc.size(); i++) begin
      cmp_cnt++;
      if (acc[i] - acc[i-1] != LAT + 1) begin
        err_cnt++; $display("FAIL b2b_period[%0d] got=%0d want=%0d", i, acc[i] - acc[i-1], LAT + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, rb; int lat;
    txn(1'b1, 32'h200, 32'hA5A55A5A, 3'b010, rd, er, lat, rb);
    model_store(32'h200, 32'hA5A55A5A, 3'b010);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    cmp_cnt += 1;
    if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy got=%b want=0", req_ready); end
    #1 rst = 1'b1;
    #1;
    cmp_cnt += 3;
    if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_req_ready got=%b want=1", req_ready); end
    if (resp_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_resp_valid got=%b want=0", resp_valid); end
    if (resp_err !== 1'b0) begin err_cnt++; $display("FAIL rstmid_err got=%b want=0", resp_err); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    txn(1'b0, 32'h200, 32'h0, 3'b010, rd, er, lat, rb);
    $display("reset mid-store, LW 0x200 rdata=%h", rd);
    cmp_cnt += 1;
    if (rd !== 32'hA5A55A5A) begin err_cnt++; $display("FAIL rstmid_store_aborted got=%h want=a5a55a5a", rd); end
    // reset while a response is pending drops it without a handshake
    resp_ready = 1'b0;
    txn(1'b0, 32'h200, 32'h0, 3'b010, rd, er, lat, rb);
    #1 rst = 1'b1;
    #1;
    cmp_cnt += 2;
    if (resp_valid !== 1'b0) begin err_cnt++; $display("FAIL rstresp_valid got=%b want=0", resp_valid); end
    if (resp_rdata !== 32'd0) begin err_cnt++; $display("FAIL rstresp_rdata got=%h want=0", resp_rdata); end
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0] f3_tbl [10];
    logic [31:0] rd, addr, wdata, want; logic er, rb, we, want_err; logic [2:0] f3; int lat;
    f3_tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    for (int n = 0; n < 150; n++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = f3_tbl[$urandom_range(0, 9)];
      addr  = {15'($urandom), 17'h01000 + 17'($urandom_range(0, 63))};
      wdata = $urandom;
      want_err = exp_err(we, addr, f3);
      want  = known(addr, f3) ? exp_load(addr, f3) : 32'd0;
      txn(we, addr, wdata, f3, rd, er, lat, rb);
      $display("rand[%0d] we=%b addr=%h f3=%0d wdata=%h rdata=%h err=%b lat=%0d", n, we, addr, f3,
               wdata, rd, er, lat);
      cmp_cnt += 2;
      if (er !== want_err) begin err_cnt++; $display("FAIL rand_err[%0d] got=%b want=%b", n, er, want_err); end
      if (lat != LAT) begin err_cnt++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", n, lat, LAT); end
      if (we || want_err || known(addr, f3)) begin
        if (we || want_err) want = 32'd0;
        cmp_cnt++;
        if (rd !== want) begin err_cnt++; $display("FAIL rand_rdata[%0d] got=%h want=%h", n, rd, want); end
      end
      if (we) model_store(addr, wdata, f3);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_misalign();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
